btn_conditioner: RTL
====================

# btn_conditioner

Parametrised multi-channel conditioner for board push-buttons and switches feeding the CPU top level (reset, clock-step and mode buttons). Each channel has a two-flop synchroniser, a cycle-count debouncer and edge detection. With the optional auto-repeat feature, a held button issues periodic press pulses. It replaces ad-hoc single-bit button handling, so every button-driven input sees clean single-cycle events.

## Interface
- `CHANNELS`, 6, number of independent button channels.
- `DEBOUNCE_CYCLES`, 100000, consecutive stable cycles required before the debounced level changes; must be ≥1.
- `REPEAT_DELAY`, 50000000, cycles from the original rise pulse to the first auto-repeat pulse; must be ≥1. Used only with `BTN_AUTOREPEAT_EN`.
- `REPEAT_PERIOD`, 10000000, cycles between successive auto-repeat pulses; must be ≥1. Used only with `BTN_AUTOREPEAT_EN`.
- `clk`  input  1  system clock; all logic on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `btn_in`  input  CHANNELS  raw asynchronous button and switch levels.
- `level`  output  CHANNELS  debounced level.
- `rise`  output  CHANNELS  one-cycle pulse when `level` goes 0→1.
- `fall`  output  CHANNELS  one-cycle pulse when `level` goes 1→0.
- `press`  output  CHANNELS  one-cycle pulse: `rise` OR an auto-repeat pulse.
- `any_press`  output  1  OR-reduction of `press`, registered in the same cycle as `press`.

## Operation
- Channels are fully independent; their logic is replicated by generate loop.
- Synchroniser: `s1 <= btn_in`, then `s2 <= s1`. Only `s2` is used downstream.
- Debounce counter width is `$clog2(DEBOUNCE_CYCLES+1)`. Compare values use the pre-edge state.
  - If `s2 == level`: clear `cnt` to 0.
  - Else, if `cnt == DEBOUNCE_CYCLES-1`: load `level <= s2`, clear `cnt` to 0, and pulse `rise` or `fall` in that same edge, so the pulse is high in the first cycle the new level is visible.
  - Else: increment `cnt`.
- Any glitch on `s2` shorter than `DEBOUNCE_CYCLES` cycles is discarded, because `cnt` restarts from 0.
- `rise`, `fall`, `press` and `any_press` are registered outputs, high for exactly one cycle per event.
- Auto-repeat (per channel) is a two-state FSM:
  - IDLE → DELAY on `rise`, with `rcnt` cleared.
  - DELAY: count up. When `rcnt == REPEAT_DELAY-1`, pulse `press`, clear `rcnt` and go to REPEAT.
  - REPEAT: when `rcnt == REPEAT_PERIOD-1`, pulse `press` and clear `rcnt`.
  - From any state, `level == 0` (including the `fall` cycle) returns to IDLE with `rcnt` cleared. No repeat pulse is issued in the `fall` cycle.
  - `rcnt` width is `$clog2(max(REPEAT_DELAY, REPEAT_PERIOD)+1)`.

## Timing
- Reset: `s1`, `s2`, `level`, `cnt`, `rise`, `fall`, `press`, `any_press`, `rcnt` and the FSM state (IDLE) all clear to 0 on the first edge with `rst=1`.
- Reset mid-debounce or mid-repeat aborts the operation with no pulse. A button held through reset produces `rise` `2+DEBOUNCE_CYCLES` edges after `rst` deasserts.
- Latency: a clean `btn_in` change set up before edge 0 reaches `s2` after edge 1 and changes `level`/`rise` after edge `1+DEBOUNCE_CYCLES`. Total latency is `2+DEBOUNCE_CYCLES` cycles.
- With `DEBOUNCE_CYCLES=1`, the level follows `s2` with one cycle of extra latency.
- First repeat `press`: `REPEAT_DELAY` cycles after the `rise`/`press` cycle. Subsequent repeats follow every `REPEAT_PERIOD` cycles.
- Counters never wrap: `cnt` is bounded by `DEBOUNCE_CYCLES-1` and `rcnt` by its terminal value.
- Simultaneous events on different channels produce same-cycle pulses. `any_press` is a single cycle in that case.

## Configuration
- `BTN_AUTOREPEAT_EN` defined: the repeat FSM and `rcnt` are compiled in, and `press` carries both `rise` and repeat pulses.
- Not defined: the FSM and `rcnt` are omitted; `press` equals `rise`; `REPEAT_DELAY` and `REPEAT_PERIOD` are ignored.

## Test plan
All scenarios use `CHANNELS=6`, `DEBOUNCE_CYCLES=4`, `REPEAT_DELAY=10`, `REPEAT_PERIOD=3`.
- Reset: `rst=1` for 2 cycles with `btn_in=6'h3F` → all outputs 0; after deassert, `level=6'h3F` and a single `rise=6'h3F` pulse 6 cycles later.
- Clean press on channel 0 → `level[0]` and a one-cycle `rise[0]`/`press[0]` 6 cycles after the edge; release → `fall[0]` 6 cycles after the edge.
- Bounce: `btn_in[5]` toggled 1,0,1,0 at 1-cycle intervals, then held 1 → exactly one `rise[5]`, 6 cycles after the final edge; no `fall`.
- Glitch: `btn_in[1]` high for 3 cycles, then low → no change on `level[1]`; no pulse.
- Auto-repeat (macro on): hold channel 2 → `press[2]` at the rise cycle T, then at T+10, T+13, T+16; release → no further pulse; `fall[2]` once. With the macro off, only the press at T occurs.
- Simultaneous: channels 3 and 4 pressed on the same edge → same-cycle `rise=6'h18`; `any_press` high for exactly 1 cycle. Also assert `rst` mid-debounce → no pulse.

Source files
------------

// File: rtl/btn_conditioner.sv
// ============================================================================
// Module      : btn_conditioner
// Description : Multi-channel button conditioner: two-flop synchroniser,
//               cycle-count debouncer, rise/fall/press pulses. Auto-repeat
//               is compiled in when BTN_AUTOREPEAT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_conditioner #(
    parameter int CHANNELS        = 6,
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] btn_in,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic [CHANNELS-1:0] press,
    output logic                any_press
);

    localparam int                 c_cnt_w    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

`ifdef BTN_AUTOREPEAT_EN
    localparam int c_rep_max = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int c_rcnt_w  = $clog2(c_rep_max + 1);
    localparam logic [c_rcnt_w-1:0] c_delay_last  = c_rcnt_w'(REPEAT_DELAY - 1);
    localparam logic [c_rcnt_w-1:0] c_period_last = c_rcnt_w'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } rep_state_t;
`endif

    if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
        $error("btn_conditioner: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
    end

    logic [CHANNELS-1:0] r_s1;
    logic [CHANNELS-1:0] r_s2;
    logic [CHANNELS-1:0] w_level_nxt;
    logic [CHANNELS-1:0] w_rise_nxt;
    logic [CHANNELS-1:0] w_fall_nxt;
    logic [CHANNELS-1:0] w_press_nxt;

    // All event outputs are registered together so they share one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1      <= '0;
            r_s2      <= '0;
            level     <= '0;
            rise      <= '0;
            fall      <= '0;
            press     <= '0;
            any_press <= 1'b0;
        end else begin
            r_s1      <= btn_in;
            r_s2      <= r_s1;
            level     <= w_level_nxt;
            rise      <= w_rise_nxt;
            fall      <= w_fall_nxt;
            press     <= w_press_nxt;
            any_press <= |w_press_nxt;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [c_cnt_w-1:0] r_cnt;
        logic [c_cnt_w-1:0] w_cnt_nxt;
        logic               w_lvl;
        logic               w_rise;
        logic               w_fall;

        // Any disagreement shorter than DEBOUNCE_CYCLES restarts the count.
        always_comb begin
            w_cnt_nxt = r_cnt;
            w_lvl     = level[i];
            w_rise    = 1'b0;
            w_fall    = 1'b0;
            if (r_s2[i] == level[i]) begin
                w_cnt_nxt = '0;
            end else if (r_cnt == c_cnt_last) begin
                w_cnt_nxt = '0;
                w_lvl     = r_s2[i];
                w_rise    = r_s2[i];
                w_fall    = ~r_s2[i];
            end else begin
                w_cnt_nxt = r_cnt + c_cnt_w'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= w_cnt_nxt;
            end
        end

        assign w_level_nxt[i] = w_lvl;
        assign w_rise_nxt[i]  = w_rise;
        assign w_fall_nxt[i]  = w_fall;

`ifdef BTN_AUTOREPEAT_EN
        rep_state_t          r_st;
        rep_state_t          w_st_nxt;
        logic [c_rcnt_w-1:0] r_rcnt;
        logic [c_rcnt_w-1:0] w_rcnt_nxt;
        logic                w_rep;

        // A falling level wins over a due repeat, so no press lands in the fall cycle.
        always_comb begin
            w_st_nxt   = r_st;
            w_rcnt_nxt = r_rcnt;
            w_rep      = 1'b0;
            if (w_rise) begin
                w_st_nxt   = ST_DELAY;
                w_rcnt_nxt = '0;
            end else if (!level[i] || w_fall) begin
                w_st_nxt   = ST_IDLE;
                w_rcnt_nxt = '0;
            end else begin
                case (r_st)
                    ST_DELAY: begin
                        if (r_rcnt == c_delay_last) begin
                            w_rep      = 1'b1;
                            w_rcnt_nxt = '0;
                            w_st_nxt   = ST_REPEAT;
                        end else begin
                            w_rcnt_nxt = r_rcnt + c_rcnt_w'(1);
                        end
                    end
                    ST_REPEAT: begin
                        if (r_rcnt == c_period_last) begin
                            w_rep      = 1'b1;
                            w_rcnt_nxt = '0;
                        end else begin
                            w_rcnt_nxt = r_rcnt + c_rcnt_w'(1);
                        end
                    end
                    default: begin
                        w_st_nxt   = ST_IDLE;
                        w_rcnt_nxt = '0;
                    end
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_st   <= ST_IDLE;
                r_rcnt <= '0;
            end else begin
                r_st   <= w_st_nxt;
                r_rcnt <= w_rcnt_nxt;
            end
        end

        assign w_press_nxt[i] = w_rise | w_rep;
`else
        assign w_press_nxt[i] = w_rise;
`endif
    end

endmodule

`default_nettype wire
